// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//   Shares one external combinational WIDTH-bit adder between two requesters.
//   A round-robin arbiter picks a requester, captures its operands, drives
//   them to the adder for one cycle, and registers the sum. The result is
//   then held with a valid/ready handshake. Only one operation is in flight
//   at a time: IDLE -> ISSUE -> RESULT -> IDLE.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   r0_valid/ready/a/b       requester 0 operand handshake
//   r1_valid/ready/a/b       requester 1 operand handshake
//   add_a, add_b             operands to the adder (zero outside ISSUE)
//   add_sum                  adder result, bit WIDTH is carry-out
//   res_valid/ready          result handshake
//   res_id                   requester that owns the result
//   res_sum                  low WIDTH bits of the sum
//   res_ov                   overflow flag
//
// Configuration macro
//   ADDER_ARB_SIGNED_OV_EN   when defined, res_ov is two's-complement
//                            overflow; otherwise it is the unsigned carry-out.
// ---------------------------------------------------------------------------
module adder_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_ov
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_res_id;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_ov;

  logic             w_any_valid;
  logic             w_grant;
  logic             w_accept;
  logic             w_ov;

  // Arbitration: a lone requester wins outright; under contention the
  // requester that did not win last time gets the grant.
  always_comb begin
    w_any_valid = r0_valid | r1_valid;
    w_grant     = (r0_valid && r1_valid) ? ~r_last_grant : r1_valid;
    w_accept    = (r_state == S_IDLE) && w_any_valid;
  end

`ifdef ADDER_ARB_SIGNED_OV_EN
  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    w_ov = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_sum[WIDTH-1] != r_a[WIDTH-1]);
  end
`else
  always_comb begin
    w_ov = add_sum[WIDTH];
  end
`endif

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_valid) w_state_next = S_ISSUE;
      S_ISSUE:  w_state_next = S_RESULT;
      S_RESULT: if (res_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_res_id     <= 1'b0;
      r_res_sum    <= '0;
      r_res_ov     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a          <= w_grant ? r1_a : r0_a;
        r_b          <= w_grant ? r1_b : r0_b;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
      end
      // Result registers only change on the ISSUE edge so they stay
      // stable for the whole RESULT phase.
      if (r_state == S_ISSUE) begin
        r_res_sum <= add_sum[WIDTH-1:0];
        r_res_ov  <= w_ov;
        r_res_id  <= r_id;
      end
    end
  end

  // Outputs
  always_comb begin
    r0_ready  = w_accept && !w_grant;
    r1_ready  = w_accept &&  w_grant;
    add_a     = (r_state == S_ISSUE) ? r_a : '0;
    add_b     = (r_state == S_ISSUE) ? r_b : '0;
    res_valid = (r_state == S_RESULT);
    res_id    = r_res_id;
    res_sum   = r_res_sum;
    res_ov    = r_res_ov;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0_valid, r0_ready, r1_valid, r1_ready;
  logic [7:0] r0_a, r0_b, r1_a, r1_b;
  logic [7:0] add_a, add_b;
  logic [8:0] add_sum;
  logic       res_valid, res_ready, res_id, res_ov;
  logic [7:0] res_sum;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared adder
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  adder_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_ov(res_ov)
  );

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       ov;
    int         acc;
  } exp_t;

  exp_t q[$];
  bit   grant_log[$];
  int   pop_cycles[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   res_seen = 0;
  bit   keep = 0;
  logic [7:0] last_sum;
  logic       last_ov, last_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b,
                                 input int acc);
    exp_t e;
    logic [8:0] s;
    s     = {1'b0, a} + {1'b0, b};
    e.id  = id;
    e.a   = a;
    e.b   = b;
    e.sum = s[7:0];
`ifdef ADDER_ARB_SIGNED_OV_EN
    e.ov  = (a[7] == b[7]) && (s[7] != a[7]);
`else
    e.ov  = s[8];
`endif
    e.acc = acc;
    return e;
  endfunction

  // One clock cycle: inputs were driven just after the previous falling
  // edge; outputs are sampled 1 time unit later, well before the rising edge.
  task automatic step();
    logic hs0, hs1;
    exp_t e;
    #1;
    hs0 = r0_valid && r0_ready;
    hs1 = r1_valid && r1_ready;
    chk("ready_exclusive", 32'(r0_ready & r1_ready), 32'd0);
    if (res_valid) chk("ready_in_result", 32'(r0_ready | r1_ready), 32'd0);
    if (q.size() == 0) begin
      chk("add_idle", 32'({add_a, add_b}), 32'd0);
    end else if (cycle == q[0].acc + 1) begin
      chk("add_a_issue", 32'(add_a), 32'(q[0].a));
      chk("add_b_issue", 32'(add_b), 32'(q[0].b));
    end
    if (res_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        if (!res_seen) begin
          chk("latency", 32'(cycle), 32'(q[0].acc + 2));
          res_seen = 1;
        end
        if (res_ready) begin
          e = q.pop_front();
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_sum", 32'(res_sum), 32'(e.sum));
          chk("res_ov", 32'(res_ov), 32'(e.ov));
          last_sum = res_sum;
          last_ov  = res_ov;
          last_id  = res_id;
          pop_cycles.push_back(cycle);
          res_seen = 0;
        end
      end
    end
    if (hs0) begin
      q.push_back(model(1'b0, r0_a, r0_b, cycle));
      grant_log.push_back(1'b0);
      $display("cycle %0d: accept r0 a=%02h b=%02h", cycle, r0_a, r0_b);
    end
    if (hs1) begin
      q.push_back(model(1'b1, r1_a, r1_b, cycle));
      grant_log.push_back(1'b1);
      $display("cycle %0d: accept r1 a=%02h b=%02h", cycle, r1_a, r1_b);
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
    if (hs0) begin
      if (keep) begin r0_a = 8'($urandom); r0_b = 8'($urandom); end
      else r0_valid = 1'b0;
    end
    if (hs1) begin
      if (keep) begin r1_a = 8'($urandom); r1_b = 8'($urandom); end
      else r1_valid = 1'b0;
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; res_ready = 1'b1;
    r0_valid = 0; r1_valid = 0;
    r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;

    // 1: reset state, then idle with no requests
    @(negedge clk); #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_ready", 32'({r0_ready, r1_ready}), 32'd0);
    chk("rst_add", 32'({add_a, add_b}), 32'd0);
    chk("rst_res_regs", 32'({res_id, res_ov, res_sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_res_valid", 32'(res_valid), 32'd0);
    chk("idle_no_grant", 32'(grant_log.size()), 32'd0);

    // 2: r0 alone
    r0_valid = 1; r0_a = 8'h12; r0_b = 8'h34;
    step();
    chk("t2_accept", 32'(grant_log.size()), 32'd1);
    drain(10);
    chk("t2_sum", 32'(last_sum), 32'h46);
    chk("t2_ov", 32'(last_ov), 32'd0);
    chk("t2_id", 32'(last_id), 32'd0);

    // 3: carry case and signed-overflow case from r1
    r1_valid = 1; r1_a = 8'hF0; r1_b = 8'h20;
    step();
    drain(10);
    chk("t3c_sum", 32'(last_sum), 32'h10);
    chk("t3c_id", 32'(last_id), 32'd1);
`ifdef ADDER_ARB_SIGNED_OV_EN
    chk("t3c_ov", 32'(last_ov), 32'd0);
`else
    chk("t3c_ov", 32'(last_ov), 32'd1);
`endif
    r1_valid = 1; r1_a = 8'h7F; r1_b = 8'h01;
    step();
    drain(10);
    chk("t3s_sum", 32'(last_sum), 32'h80);
`ifdef ADDER_ARB_SIGNED_OV_EN
    chk("t3s_ov", 32'(last_ov), 32'd1);
`else
    chk("t3s_ov", 32'(last_ov), 32'd0);
`endif

    // 4: both requesters continuously valid, consumer always ready
    grant_log.delete(); pop_cycles.delete();
    keep = 1;
    r0_valid = 1; r0_a = 8'($urandom); r0_b = 8'($urandom);
    r1_valid = 1; r1_a = 8'($urandom); r1_b = 8'($urandom);
    repeat (12) step();
    keep = 0; r0_valid = 0; r1_valid = 0;
    drain(10);
    chk("t4_grants", 32'(grant_log.size() >= 4), 32'd1);
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t4_grant_order", 32'(grant_log[i]), 32'(i % 2));
    end
    chk("t4_results", 32'(pop_cycles.size() >= 4), 32'd1);
    if (pop_cycles.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        chk("t4_spacing", 32'(pop_cycles[i] - pop_cycles[i-1]), 32'd3);
    end

    // 5: backpressure, with r1 waiting during RESULT
    res_ready = 0;
    r0_valid = 1; r0_a = 8'h55; r0_b = 8'h22;
    step();
    step();
    r1_valid = 1; r1_a = 8'h01; r1_b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("t5_hold_valid", 32'(res_valid), 32'd1);
      chk("t5_hold_sum", 32'(res_sum), 32'h77);
      chk("t5_no_ready", 32'({r0_ready, r1_ready}), 32'd0);
    end
    res_ready = 1;
    step();
    chk("t5_sum", 32'(last_sum), 32'h77);
    #1;
    chk("t5_next_grant", 32'(r1_ready), 32'd1);
    drain(10);

    // 6: reset while an r0 op is in ISSUE
    r0_valid = 1; r0_a = 8'hAA; r0_b = 8'h11;
    step();
    rst_n = 0; r0_valid = 0; r1_valid = 0;
    #1;
    chk("t6_res_valid", 32'(res_valid), 32'd0);
    chk("t6_add", 32'({add_a, add_b}), 32'd0);
    q.delete(); res_seen = 0;
    repeat (3) step();
    rst_n = 1;
    grant_log.delete();
    r0_valid = 1; r0_a = 8'h03; r0_b = 8'h04;
    r1_valid = 1; r1_a = 8'h05; r1_b = 8'h06;
    for (int n = 0; n < 5 && grant_log.size() == 0; n++) step();
    chk("t6_granted", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() != 0) chk("t6_first_grant", 32'(grant_log[0]), 32'd0);
    r1_valid = 0;
    drain(10);
    chk("t6_sum", 32'(last_sum), 32'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
